int_wb_stage: RTL and testbench
===============================

Name: int_wb_stage

Overview:
- Integer writeback stage directly upstream of the integer register file.
- Arbitrates between two result sources:
  - single-cycle ALU results;
  - handshaked load-unit responses.
- Formats load data (byte/halfword select, sign/zero extension) and drives the register-file write port through one register stage.
- Exposes the same registered write as a forwarding tap for the operand-read stage.

Parameters:
- AW, 5, register address width (32 registers).
- DW, 32, data width.
- STARVE_MAX, 3, consecutive cycles a pending load may lose to the ALU before it is forced to win.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- alu_valid  input  1  ALU result present this cycle
- alu_rd  input  AW  ALU destination register
- alu_result  input  DW  ALU result
- alu_stall  output  1  combinational; 1 = ALU result not accepted, source must hold alu_rd/alu_result
- ld_valid  input  1  load response present
- ld_ready  output  1  combinational; load accepted when ld_valid & ld_ready
- ld_rd  input  AW  load destination register
- ld_rdata  input  DW  raw aligned 32-bit word from memory
- ld_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_addr_lo  input  2  byte offset of load address
- we  output  1  register-file write enable (registered)
- write_address  output  AW  register-file write address (registered)
- data_in  output  DW  register-file write data (registered)
- ld_err  output  1  one-cycle pulse (registered): accepted load was illegal or misaligned

Behaviour:
- Reset: rst_n=0 at a clock edge clears we, write_address, data_in, ld_err and the starve counter to 0. Reset wins over any concurrent handshake.
- Reset mid-operation: any pending ALU or load result is dropped and no write occurs. The source re-presents it after reset if required.
- Arbitration (combinational, per cycle), with load_pri = (starve_cnt == STARVE_MAX):
  - Only ALU valid: ALU accepted, alu_stall=0.
  - Only load valid: load accepted, ld_ready=1.
  - Both valid, load_pri=0: ALU wins, alu_stall=0, ld_ready=0.
  - Both valid, load_pri=1: load wins, ld_ready=1, alu_stall=1.
  - Neither valid: alu_stall=0, ld_ready=1.
- Starve counter (sequential):
  - Increments when ld_valid & alu_valid & !load_pri.
  - Clears to 0 when a load is accepted, or when ld_valid=0.
  - Saturates at STARVE_MAX.
- Latency: the result accepted in cycle N appears on we/write_address/data_in in cycle N+1, held for exactly one cycle. In any cycle with no acceptance, we=0 next cycle.
- x0 rule: an accepted result with rd=0 still completes its handshake, but we=0. write_address and data_in still update.
- Load formatting (b = ld_addr_lo):
  - LB/LBU: byte ld_rdata[8b+7:8b], sign-/zero-extended to DW.
  - LH/LHU: legal only if b[0]=0; half ld_rdata[16b[1]+15:16b[1]], sign-/zero-extended.
  - LW: legal only if b=00; word passed unchanged.
- Illegal or misaligned load:
  - funct3 011/110/111, or a misaligned LH/LHU/LW.
  - The load is still accepted (ld_ready as normal).
  - Next cycle: we=0, ld_err=1 for one cycle, data_in=0.
- ALU results are written unmodified.
- No internal buffering beyond the output register: there is no skid entry, and backpressure is purely combinational.
- Back-to-back: a new acceptance each cycle yields a write each cycle. There is no bubble between consecutive writes.

Test Plan:
1. Reset then ALU only: alu_valid=1, alu_rd=5, alu_result=0xDEADBEEF at cycle 1 -> cycle 2 shows we=1, write_address=5, data_in=0xDEADBEEF; cycle 3 shows we=0.
2. Load formatting:
   - ld_rdata=0x80F07F12 with LB, b=3 -> data_in=0xFFFFFF80.
   - Same data with LBU, b=2 -> 0x000000F0.
   - Same data with LH, b=2 -> 0xFFFF80F0.
   - Same data with LHU, b=0 -> 0x00007F12.
   - Each gives we=1, ld_err=0.
3. Misaligned and illegal loads:
   - LW with b=01 -> ld_ready=1; next cycle we=0, ld_err=1 for one cycle.
   - funct3=011 -> same response.
4. Contention with STARVE_MAX=3: alu_valid and ld_valid both held high, ALU holding its data when stalled:
   - Cycles 1–3: ALU wins, ld_ready=0.
   - Cycle 4: ld_ready=1, alu_stall=1.
   - Cycle 5: counter is 0 and ALU wins again.
   - Write sequence is ALU, ALU, ALU, LOAD, ALU.
5. x0 suppression: ALU result with rd=0 and a load with ld_rd=0 -> handshakes complete (alu_stall=0, ld_ready=1), we stays 0.
6. Reset mid-contention: pull rst_n low while starve_cnt=2 -> next cycle we=0, ld_err=0; after release, a load needs 3 more losing cycles before it is forced.

Source files
------------

// File: rtl/int_wb_stage.sv
// rtl/int_wb_stage.sv - integer writeback stage: ALU/load arbitration, load formatting, registered RF write
module int_wb_stage #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_result,
  output logic          alu_stall,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_rd,
  input  logic [DW-1:0] ld_rdata,
  input  logic [2:0]    ld_funct3,
  input  logic [1:0]    ld_addr_lo,
  output logic          we,
  output logic [AW-1:0] write_address,
  output logic [DW-1:0] data_in,
  output logic          ld_err
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          load_pri;
  logic          ld_acc;
  logic          alu_acc;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] ld_fmt;
  logic          ld_legal;

  // The load only loses while the ALU is present and the starve counter has not saturated.
  assign load_pri  = (starve_cnt == CW'(STARVE_MAX));
  assign ld_ready  = !alu_valid || load_pri;
  assign alu_stall = alu_valid && ld_valid && load_pri;
  assign ld_acc    = ld_valid && ld_ready;
  assign alu_acc   = alu_valid && !alu_stall;

  assign byte_sel = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
  assign half_sel = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  always_comb begin
    ld_fmt   = '0;
    ld_legal = 1'b0;
    case (ld_funct3)
      3'b000: begin
        ld_fmt   = {{(DW-8){byte_sel[7]}}, byte_sel};
        ld_legal = 1'b1;
      end
      3'b100: begin
        ld_fmt   = {{(DW-8){1'b0}}, byte_sel};
        ld_legal = 1'b1;
      end
      3'b001: begin
        ld_fmt   = {{(DW-16){half_sel[15]}}, half_sel};
        ld_legal = !ld_addr_lo[0];
      end
      3'b101: begin
        ld_fmt   = {{(DW-16){1'b0}}, half_sel};
        ld_legal = !ld_addr_lo[0];
      end
      3'b010: begin
        ld_fmt   = ld_rdata;
        ld_legal = (ld_addr_lo == 2'b00);
      end
      default: begin
        ld_fmt   = '0;
        ld_legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we            <= 1'b0;
      write_address <= '0;
      data_in       <= '0;
      ld_err        <= 1'b0;
      starve_cnt    <= '0;
    end else begin
      we     <= 1'b0;
      ld_err <= 1'b0;
      if (ld_acc) begin
        write_address <= ld_rd;
        data_in       <= ld_legal ? ld_fmt : '0;
        we            <= ld_legal && (ld_rd != '0);
        ld_err        <= !ld_legal;
      end else if (alu_acc) begin
        write_address <= alu_rd;
        data_in       <= alu_result;
        we            <= (alu_rd != '0);
      end

      if (ld_acc || !ld_valid) begin
        starve_cnt <= '0;
      end else if (alu_valid && !load_pri) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_int_wb_stage.sv
// tb/tb_int_wb_stage.sv - table-driven scoreboard bench for int_wb_stage
module tb_int_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_rdata;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        we;
  logic [4:0]  write_address;
  logic [31:0] data_in;
  logic        ld_err;

  int_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_rdata(ld_rdata),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .we(we), .write_address(write_address), .data_in(data_in), .ld_err(ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ares;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic        estall;
    logic        erdy;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ed;
    logic        eerr;
    logic        chkwd;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] d;
    logic        err;
    logic        chk;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  function automatic vec_t row(input logic rst, input logic av, input logic [4:0] ard,
                               input logic [31:0] ares, input logic lv, input logic [4:0] lrd,
                               input logic [31:0] ldat, input logic [2:0] f3, input logic [1:0] lo,
                               input logic estall, input logic erdy, input logic ewe,
                               input logic [4:0] ewa, input logic [31:0] ed, input logic eerr,
                               input logic chkwd);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.ares = ares;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat; v.f3 = f3; v.lo = lo;
    v.estall = estall; v.erdy = erdy; v.ewe = ewe; v.ewa = ewa;
    v.ed = ed; v.eerr = eerr; v.chkwd = chkwd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s (vector %0d): got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    rst_n      = !v.rst;
    alu_valid  = v.av;
    alu_rd     = v.ard;
    alu_result = v.ares;
    ld_valid   = v.lv;
    ld_rd      = v.lrd;
    ld_rdata   = v.ldat;
    ld_funct3  = v.f3;
    ld_addr_lo = v.lo;
    #1;
    if (!v.rst) begin
      chk("alu_stall", idx, alu_stall, v.estall);
      if (v.lv || !v.av) chk("ld_ready", idx, ld_ready, v.erdy);
    end
    sb.push_back('{we: v.ewe, wa: v.ewa, d: v.ed, err: v.eerr, chk: v.chkwd, idx: idx});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("we", e.idx, we, e.we);
    chk("ld_err", e.idx, ld_err, e.err);
    if (e.chk) begin
      chk("write_address", e.idx, write_address, e.wa);
      chk("data_in", e.idx, data_in, e.d);
    end
  endtask

  localparam logic [31:0] D  = 32'h80F07F12;
  localparam logic [31:0] LD = 32'hCAFEF00D;

  initial begin
    rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_rdata = '0; ld_funct3 = '0; ld_addr_lo = '0;

    // reset state, then single-cycle ALU write and load formatting
    vecs.push_back(row(1, 0, 0, 0,            0, 0,  0, 3'b000, 0, 0, 0, 0, 0,  0,            0, 1));
    vecs.push_back(row(1, 1, 3, 32'h1234,     1, 4,  D, 3'b010, 0, 0, 0, 0, 0,  0,            0, 1));
    vecs.push_back(row(0, 1, 5, 32'hDEADBEEF, 0, 0,  0, 3'b000, 0, 0, 0, 1, 5,  32'hDEADBEEF, 0, 1));
    vecs.push_back(row(0, 0, 0, 0,            0, 0,  0, 3'b000, 0, 0, 1, 0, 0,  0,            0, 0));
    vecs.push_back(row(0, 0, 0, 0,            1, 3,  D, 3'b000, 3, 0, 1, 1, 3,  32'hFFFFFF80, 0, 1));
    vecs.push_back(row(0, 0, 0, 0,            1, 4,  D, 3'b100, 2, 0, 1, 1, 4,  32'h000000F0, 0, 1));
    vecs.push_back(row(0, 0, 0, 0,            1, 6,  D, 3'b001, 2, 0, 1, 1, 6,  32'hFFFF80F0, 0, 1));
    vecs.push_back(row(0, 0, 0, 0,            1, 7,  D, 3'b101, 0, 0, 1, 1, 7,  32'h00007F12, 0, 1));
    vecs.push_back(row(0, 0, 0, 0,            1, 8,  D, 3'b010, 0, 0, 1, 1, 8,  32'h80F07F12, 0, 1));
    vecs.push_back(row(0, 0, 0, 0,            1, 9,  D, 3'b000, 1, 0, 1, 1, 9,  32'h0000007F, 0, 1));
    vecs.push_back(row(0, 0, 0, 0,            1, 10, D, 3'b101, 2, 0, 1, 1, 10, 32'h000080F0, 0, 1));
    vecs.push_back(row(0, 0, 0, 0,            1, 11, D, 3'b001, 0, 0, 1, 1, 11, 32'h00007F12, 0, 1));
    // illegal / misaligned loads: accepted, no write, one-cycle error
    vecs.push_back(row(0, 0, 0, 0,            1, 12, D, 3'b010, 1, 0, 1, 0, 12, 0,            1, 1));
    vecs.push_back(row(0, 0, 0, 0,            1, 13, D, 3'b011, 0, 0, 1, 0, 13, 0,            1, 1));
    vecs.push_back(row(0, 0, 0, 0,            1, 14, D, 3'b001, 1, 0, 1, 0, 14, 0,            1, 1));
    vecs.push_back(row(0, 0, 0, 0,            1, 15, D, 3'b111, 0, 0, 1, 0, 15, 0,            1, 1));
    vecs.push_back(row(0, 0, 0, 0,            1, 16, D, 3'b010, 2, 0, 1, 0, 16, 0,            1, 1));
    vecs.push_back(row(0, 0, 0, 0,            0, 0,  0, 3'b000, 0, 0, 1, 0, 0,  0,            0, 0));
    // x0 destinations
    vecs.push_back(row(0, 1, 0, 32'h55,       0, 0,  0, 3'b000, 0, 0, 0, 0, 0,  32'h55,       0, 1));
    vecs.push_back(row(0, 0, 0, 0,            1, 0,  D, 3'b010, 0, 0, 1, 0, 0,  D,            0, 1));
    vecs.push_back(row(0, 0, 0, 0,            0, 0,  0, 3'b000, 0, 0, 1, 0, 0,  0,            0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // contention: ALU wins three times, load forced on the fourth, ALU (held data) next
    vecs.delete();
    vecs.push_back(row(0, 1, 7, 32'h101, 1, 9, LD, 3'b010, 0, 0, 0, 1, 7, 32'h101, 0, 1));
    vecs.push_back(row(0, 1, 7, 32'h102, 1, 9, LD, 3'b010, 0, 0, 0, 1, 7, 32'h102, 0, 1));
    vecs.push_back(row(0, 1, 7, 32'h103, 1, 9, LD, 3'b010, 0, 0, 0, 1, 7, 32'h103, 0, 1));
    vecs.push_back(row(0, 1, 7, 32'h104, 1, 9, LD, 3'b010, 0, 1, 1, 1, 9, LD,      0, 1));
    vecs.push_back(row(0, 1, 7, 32'h104, 1, 9, LD, 3'b010, 0, 0, 0, 1, 7, 32'h104, 0, 1));
    vecs.push_back(row(0, 0, 0, 0,       0, 0, 0,  3'b000, 0, 0, 1, 0, 0, 0,       0, 0));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 100 + i);

    // reset with the starve counter at 2: counter restarts, load forced only after 3 more losses
    vecs.delete();
    vecs.push_back(row(0, 1, 7, 32'h201, 1, 9, LD, 3'b010, 0, 0, 0, 1, 7, 32'h201, 0, 1));
    vecs.push_back(row(0, 1, 7, 32'h202, 1, 9, LD, 3'b010, 0, 0, 0, 1, 7, 32'h202, 0, 1));
    vecs.push_back(row(1, 1, 7, 32'h203, 1, 9, LD, 3'b010, 0, 0, 0, 0, 0, 0,       0, 1));
    vecs.push_back(row(0, 1, 7, 32'h203, 1, 9, LD, 3'b010, 0, 0, 0, 1, 7, 32'h203, 0, 1));
    vecs.push_back(row(0, 1, 7, 32'h204, 1, 9, LD, 3'b010, 0, 0, 0, 1, 7, 32'h204, 0, 1));
    vecs.push_back(row(0, 1, 7, 32'h205, 1, 9, LD, 3'b010, 0, 0, 0, 1, 7, 32'h205, 0, 1));
    vecs.push_back(row(0, 1, 7, 32'h206, 1, 9, LD, 3'b010, 0, 1, 1, 1, 9, LD,      0, 1));
    vecs.push_back(row(0, 1, 7, 32'h206, 1, 9, LD, 3'b010, 0, 0, 0, 1, 7, 32'h206, 0, 1));
    vecs.push_back(row(0, 0, 0, 0,       0, 0, 0,  3'b000, 0, 0, 1, 0, 0, 0,       0, 0));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 200 + i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
